// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: tracks make/break/E0 scan-code sequences and shows the last held key, its ASCII and the press count on six 7-segment digits.
module ps2_scancode_decoder #(
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int IGNORE_REPEAT  = 1
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   output logic       key_down,
   output logic [7:0] scan_code,
   output logic       ext_key,
   output logic [7:0] ascii,
   output logic [7:0] key_count,
   output logic [7:0] seg0,
   output logic [7:0] seg1,
   output logic [7:0] seg2,
   output logic [7:0] seg3,
   output logic [7:0] seg4,
   output logic [7:0] seg5
);
   typedef enum logic [1:0] {IDLE, EXT, BREAK, EXT_BREAK} state_t;
   localparam logic [7:0] SEG_INV = (SEG_ACTIVE_LOW != 0) ? 8'h00 : 8'hFF;

   function automatic logic [7:0] f_glyph(input logic [3:0] n);
      case (n)
         4'h0: f_glyph = 8'hC0;  4'h1: f_glyph = 8'hF9;  4'h2: f_glyph = 8'hA4;  4'h3: f_glyph = 8'hB0;
         4'h4: f_glyph = 8'h99;  4'h5: f_glyph = 8'h92;  4'h6: f_glyph = 8'h82;  4'h7: f_glyph = 8'hF8;
         4'h8: f_glyph = 8'h80;  4'h9: f_glyph = 8'h90;  4'hA: f_glyph = 8'h88;  4'hB: f_glyph = 8'h83;
         4'hC: f_glyph = 8'hC6;  4'hD: f_glyph = 8'hA1;  4'hE: f_glyph = 8'h86;  default: f_glyph = 8'h8E;
      endcase
   endfunction

   function automatic logic [7:0] f_seg(input logic [3:0] n, input logic on);
      f_seg = (on ? f_glyph(n) : 8'hFF) ^ SEG_INV;
   endfunction

   function automatic logic [7:0] f_ascii(input logic [7:0] c);
      case (c)
         8'h1C: f_ascii = 8'h61;  8'h32: f_ascii = 8'h62;  8'h21: f_ascii = 8'h63;  8'h23: f_ascii = 8'h64;
         8'h24: f_ascii = 8'h65;  8'h2B: f_ascii = 8'h66;  8'h34: f_ascii = 8'h67;  8'h33: f_ascii = 8'h68;
         8'h43: f_ascii = 8'h69;  8'h3B: f_ascii = 8'h6A;  8'h42: f_ascii = 8'h6B;  8'h4B: f_ascii = 8'h6C;
         8'h3A: f_ascii = 8'h6D;  8'h31: f_ascii = 8'h6E;  8'h44: f_ascii = 8'h6F;  8'h4D: f_ascii = 8'h70;
         8'h15: f_ascii = 8'h71;  8'h2D: f_ascii = 8'h72;  8'h1B: f_ascii = 8'h73;  8'h2C: f_ascii = 8'h74;
         8'h3C: f_ascii = 8'h75;  8'h2A: f_ascii = 8'h76;  8'h1D: f_ascii = 8'h77;  8'h22: f_ascii = 8'h78;
         8'h35: f_ascii = 8'h79;  8'h1A: f_ascii = 8'h7A;
         8'h45: f_ascii = 8'h30;  8'h16: f_ascii = 8'h31;  8'h1E: f_ascii = 8'h32;  8'h26: f_ascii = 8'h33;
         8'h25: f_ascii = 8'h34;  8'h2E: f_ascii = 8'h35;  8'h36: f_ascii = 8'h36;  8'h3D: f_ascii = 8'h37;
         8'h3E: f_ascii = 8'h38;  8'h46: f_ascii = 8'h39;
         8'h29: f_ascii = 8'h20;  8'h5A: f_ascii = 8'h0D;
         default: f_ascii = 8'h00;
      endcase
   endfunction

   state_t     r_state;
   state_t     w_state;
   logic       w_e, w_same, w_pfx, w_ign, w_mk, w_new, w_brk, w_down, w_ext;
   logic [7:0] w_code, w_ascii, w_cnt;

   assign w_e    = (r_state == EXT) || (r_state == EXT_BREAK);
   assign w_same = key_down && (byte_data == scan_code) && (w_e == ext_key);
   assign w_pfx  = (byte_data == 8'hE0) || (byte_data == 8'hF0);
   assign w_ign  = byte_data inside {8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF};
   assign w_mk   = byte_valid && !w_pfx && ((r_state == EXT) || ((r_state == IDLE) && !w_ign));
   assign w_brk  = byte_valid && !w_pfx && ((r_state == BREAK) || (r_state == EXT_BREAK)) && w_same;
   assign w_new  = w_mk && !w_same;

   // Next-state values feed both the state registers and the registered digits so they agree on the same edge.
   always_comb begin
      w_state = !byte_valid      ? r_state :
                r_state == IDLE  ? (byte_data == 8'hE0 ? EXT : byte_data == 8'hF0 ? BREAK : IDLE) :
                r_state == EXT   ? (byte_data == 8'hF0 ? EXT_BREAK : byte_data == 8'hE0 ? EXT : IDLE) :
                IDLE;
      w_down  = w_new ? 1'b1 : w_brk ? 1'b0 : key_down;
      w_code  = w_new ? byte_data : scan_code;
      w_ext   = w_new ? w_e : ext_key;
      w_ascii = w_new ? (w_e ? 8'h00 : f_ascii(byte_data)) : ascii;
      w_cnt   = key_count + {7'd0, w_new || (w_mk && IGNORE_REPEAT == 0)};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= IDLE;
         key_down  <= 1'b0;
         scan_code <= 8'h00;
         ext_key   <= 1'b0;
         ascii     <= 8'h00;
         key_count <= 8'h00;
         seg0      <= 8'hFF ^ SEG_INV;
         seg1      <= 8'hFF ^ SEG_INV;
         seg2      <= 8'hFF ^ SEG_INV;
         seg3      <= 8'hFF ^ SEG_INV;
         seg4      <= 8'hC0 ^ SEG_INV;
         seg5      <= 8'hC0 ^ SEG_INV;
      end else begin
         r_state   <= w_state;
         key_down  <= w_down;
         scan_code <= w_code;
         ext_key   <= w_ext;
         ascii     <= w_ascii;
         key_count <= w_cnt;
         seg0      <= f_seg(w_code[3:0], w_down);
         seg1      <= f_seg(w_code[7:4], w_down);
         seg2      <= f_seg(w_ascii[3:0], w_down);
         seg3      <= f_seg(w_ascii[7:4], w_down);
         seg4      <= f_seg(w_cnt[3:0], 1'b1);
         seg5      <= f_seg(w_cnt[7:4], 1'b1);
      end
   end
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder: directed byte sequences against a default instance and an active-high, count-every-make instance.
module tb_ps2_scancode_decoder;
   logic       clk, resetn, byte_valid;
   logic [7:0] byte_data;
   logic       a_down, a_ext, b_down, b_ext;
   logic [7:0] a_scan, a_ascii, a_cnt, a_s0, a_s1, a_s2, a_s3, a_s4, a_s5;
   logic [7:0] b_scan, b_ascii, b_cnt, b_s0, b_s1, b_s2, b_s3, b_s4, b_s5;
   int         n_pass = 0, n_tot = 0;

   ps2_scancode_decoder dut_a (
      .clk(clk), .resetn(resetn), .byte_valid(byte_valid), .byte_data(byte_data),
      .key_down(a_down), .scan_code(a_scan), .ext_key(a_ext), .ascii(a_ascii), .key_count(a_cnt),
      .seg0(a_s0), .seg1(a_s1), .seg2(a_s2), .seg3(a_s3), .seg4(a_s4), .seg5(a_s5));

   ps2_scancode_decoder #(.SEG_ACTIVE_LOW(0), .IGNORE_REPEAT(0)) dut_b (
      .clk(clk), .resetn(resetn), .byte_valid(byte_valid), .byte_data(byte_data),
      .key_down(b_down), .scan_code(b_scan), .ext_key(b_ext), .ascii(b_ascii), .key_count(b_cnt),
      .seg0(b_s0), .seg1(b_s1), .seg2(b_s2), .seg3(b_s3), .seg4(b_s4), .seg5(b_s5));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] req);
      n_tot++;
      assert (obs === req) n_pass++;
      else $error("FAIL %s: observed %h required %h", tag, obs, req);
   endtask

   task automatic send(input logic [7:0] b);
      byte_valid = 1'b1;
      byte_data  = b;
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   initial begin
      resetn = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
      #12;
      chk("rst_down", {7'd0, a_down}, 8'h00);
      chk("rst_scan", a_scan, 8'h00);
      chk("rst_ext", {7'd0, a_ext}, 8'h00);
      chk("rst_ascii", a_ascii, 8'h00);
      chk("rst_cnt", a_cnt, 8'h00);
      chk("rst_seg0", a_s0, 8'hFF);
      chk("rst_seg3", a_s3, 8'hFF);
      chk("rst_seg4", a_s4, 8'hC0);
      chk("rst_seg5", a_s5, 8'hC0);
      chk("rst_b_seg0", b_s0, 8'h00);
      chk("rst_b_seg4", b_s4, 8'h3F);
      @(negedge clk); resetn = 1'b1;
      @(negedge clk);
      chk("idle_cnt", a_cnt, 8'h00);
      send(8'h1C);
      chk("a_down", {7'd0, a_down}, 8'h01);
      chk("a_scan", a_scan, 8'h1C);
      chk("a_ascii", a_ascii, 8'h61);
      chk("a_cnt", a_cnt, 8'h01);
      chk("a_seg1", a_s1, 8'hF9);
      chk("a_seg0", a_s0, 8'hC6);
      chk("a_seg3", a_s3, 8'h82);
      chk("a_seg2", a_s2, 8'hF9);
      chk("a_seg4", a_s4, 8'hF9);
      chk("a_b_seg0", b_s0, 8'h39);
      send(8'hF0);
      chk("brk_pending_down", {7'd0, a_down}, 8'h01);
      send(8'h1C);
      chk("a_rel_down", {7'd0, a_down}, 8'h00);
      chk("a_rel_seg0", a_s0, 8'hFF);
      chk("a_rel_seg1", a_s1, 8'hFF);
      chk("a_rel_seg2", a_s2, 8'hFF);
      chk("a_rel_seg3", a_s3, 8'hFF);
      chk("a_rel_cnt", a_cnt, 8'h01);
      chk("a_rel_seg4", a_s4, 8'hF9);
      send(8'h1C); send(8'h1C); send(8'h1C);
      chk("rep_cnt_ign", a_cnt, 8'h02);
      chk("rep_cnt_all", b_cnt, 8'h04);
      chk("rep_b_seg4", b_s4, 8'h66);
      chk("rep_down", {7'd0, a_down}, 8'h01);
      send(8'hF0); send(8'h1C);
      chk("rep_rel", {7'd0, a_down}, 8'h00);
      send(8'hE0);
      chk("e0_only_down", {7'd0, a_down}, 8'h00);
      send(8'h75);
      chk("ext_ext", {7'd0, a_ext}, 8'h01);
      chk("ext_scan", a_scan, 8'h75);
      chk("ext_ascii", a_ascii, 8'h00);
      chk("ext_cnt", a_cnt, 8'h03);
      send(8'hE0); send(8'hF0); send(8'h75);
      chk("ext_rel", {7'd0, a_down}, 8'h00);
      send(8'hE0); send(8'h75);
      chk("ext2_cnt", a_cnt, 8'h04);
      send(8'h75);
      chk("plain_cnt", a_cnt, 8'h05);
      chk("plain_ext", {7'd0, a_ext}, 8'h00);
      chk("plain_b_cnt", b_cnt, 8'h07);
      send(8'hE0); send(8'hF0); send(8'h75);
      chk("ext_rel_mismatch", {7'd0, a_down}, 8'h01);
      send(8'hF0); send(8'h75);
      chk("plain_rel", {7'd0, a_down}, 8'h00);
      send(8'h15); send(8'h16);
      chk("last_scan", a_scan, 8'h16);
      chk("last_ascii", a_ascii, 8'h31);
      chk("last_cnt", a_cnt, 8'h07);
      send(8'hF0); send(8'h15);
      chk("old_rel_down", {7'd0, a_down}, 8'h01);
      send(8'hF0); send(8'h16);
      chk("new_rel_down", {7'd0, a_down}, 8'h00);
      send(8'hAA); send(8'hFA);
      chk("ign_cnt", a_cnt, 8'h07);
      chk("ign_down", {7'd0, a_down}, 8'h00);
      send(8'hF0); send(8'h29);
      chk("orphan_down", {7'd0, a_down}, 8'h00);
      chk("orphan_cnt", a_cnt, 8'h07);
      send(8'h29);
      chk("space_ascii", a_ascii, 8'h20);
      chk("space_cnt", a_cnt, 8'h08);
      chk("space_seg3", a_s3, 8'hA4);
      chk("space_seg2", a_s2, 8'hC0);
      send(8'hF0); send(8'hE0); send(8'h1C);
      chk("proto_err_ext", {7'd0, a_ext}, 8'h00);
      chk("proto_err_scan", a_scan, 8'h1C);
      chk("proto_err_cnt", a_cnt, 8'h09);
      resetn = 1'b0; #2; @(negedge clk); resetn = 1'b1; @(negedge clk);
      for (int i = 0; i < 256; i++) send(i[0] ? 8'h32 : 8'h1C);
      chk("wrap_cnt", a_cnt, 8'h00);
      chk("wrap_seg5", a_s5, 8'hC0);
      chk("wrap_seg4", a_s4, 8'hC0);
      chk("wrap_b_cnt", b_cnt, 8'h00);
      chk("wrap_scan", a_scan, 8'h32);
      chk("wrap_ascii", a_ascii, 8'h62);
      send(8'hE0);
      #2 resetn = 1'b0;
      #1;
      chk("mid_rst_down", {7'd0, a_down}, 8'h00);
      chk("mid_rst_cnt", a_cnt, 8'h00);
      @(negedge clk); resetn = 1'b1; @(negedge clk);
      send(8'h1C);
      chk("post_rst_ext", {7'd0, a_ext}, 8'h00);
      chk("post_rst_scan", a_scan, 8'h1C);
      chk("post_rst_cnt", a_cnt, 8'h01);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Downstream consumer of the PS/2 keyboard frame receiver.
- Accepts validated scan-code bytes as one-cycle strobes and tracks make, break and extended (E0) sequences with a small state machine.
- Tracks the single most recent pressed key, translates it to ASCII, and counts distinct key presses.
- Drives six seven-segment digits on the board: scan code, ASCII and press count.

Parameters:
SEG_ACTIVE_LOW, 1, 1: segment outputs active-low (lit = 0); 0: active-high (all seg bits inverted).
IGNORE_REPEAT, 1, 1: typematic repeats of the held key do not increment key_count; 0: every make byte counts.

Ports:
clk  input  1  system clock.
resetn  input  1  asynchronous active-low reset.
byte_valid  input  1  one-cycle strobe from the receiver: byte_data holds a parity/start/stop-checked byte.
byte_data  input  8  received scan-code byte.
key_down  output  1  a tracked key is currently held.
scan_code  output  8  make code of the tracked key.
ext_key  output  1  tracked key was E0-prefixed.
ascii  output  8  ASCII of the tracked key, 0x00 if unmapped or extended.
key_count  output  8  number of distinct presses, wraps 0xFF->0x00.
seg0..seg5  output  8 each  7-seg digits {dp,g,f,e,d,c,b,a}: seg1:seg0 = scan_code hex, seg3:seg2 = ascii hex, seg5:seg4 = key_count hex.

Behaviour:
- Reset (asynchronous, resetn=0): state=IDLE, key_down=0, scan_code=0x00, ext_key=0, ascii=0x00, key_count=0x00.
  - seg0..seg3 blank (all segments off, 0xFF when active-low).
  - seg4/seg5 show "0" (0xC0 when active-low).
- Reset asserted mid-sequence discards any pending prefix.
- All state and outputs are registered. A byte accepted on edge N is visible after edge N. Bytes arrive no faster than one per cycle; no backpressure.
- No change when byte_valid=0.
- FSM states: IDLE, EXT, BREAK, EXT_BREAK.
- IDLE:
  - 0xE0 -> EXT.
  - 0xF0 -> BREAK.
  - 0x00, 0xAA, 0xFA, 0xFE, 0xFF: ignored, stay IDLE.
  - Any other byte: make code with ext=0, then MAKE rule.
- EXT:
  - 0xF0 -> EXT_BREAK.
  - 0xE0: stay EXT.
  - Any other byte: make code with ext=1, then MAKE rule, then -> IDLE.
- BREAK / EXT_BREAK:
  - Next byte is a break code with ext=0 (BREAK) or ext=1 (EXT_BREAK).
  - If key_down=1, byte==scan_code and ext matches ext_key: key_down<=0. Otherwise the byte is ignored (release of a non-tracked key).
  - E0 or F0 in this position is a protocol error: nothing changes.
  - Always -> IDLE.
- MAKE rule:
  - If key_down=1, code==scan_code and ext==ext_key: typematic repeat. No change, except key_count+1 when IGNORE_REPEAT=0.
  - Otherwise: scan_code<=code, ext_key<=ext, key_down<=1, ascii<=lookup, key_count<=key_count+1 (mod 256).
  - A new key pressed while another is held replaces it (last key wins).
- ASCII lookup (ext=0 only, lowercase, no shift handling):
  - Letters: 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z.
  - Digits: 45 '0', 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9'.
  - Others: 29 -> 0x20, 5A -> 0x0D.
  - Any other code -> 0x00.
- Display:
  - seg0..seg3 blank while key_down=0. When key_down=1, they show scan_code and ascii as hex.
  - dp is always off.
  - Hex glyphs, active-low: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.

Test Plan:
- Reset, then bytes 1C, F0, 1C -> after 1C: key_down=1, scan_code=0x1C, ascii=0x61, key_count=1, seg1=F9, seg0=C6. After the final 1C: key_down=0, seg0..3=FF, key_count=1.
- Bytes 1C, 1C, 1C (repeat) -> key_count=1 with IGNORE_REPEAT=1; key_count=3 with IGNORE_REPEAT=0.
- Bytes E0, 75, E0, F0, 75 -> ext_key=1, scan_code=0x75, ascii=0x00, key_count=1, then key_down=0. A plain 75 while the E0 75 key is held counts as a new press (key_count=2).
- Bytes 15, 16 (q held, then 1) -> scan_code=0x16, ascii=0x31, key_count=2. Then F0 15 -> key_down stays 1. Then F0 16 -> key_down=0.
- Bytes AA, FA, then F0 with no prior make, then 29 -> AA/FA ignored. The F0 29 pair leaves key_down=0 and key_count=0. A following 29 gives ascii=0x20, key_count=1.
- 256 distinct alternating presses (1C, 32, ...) -> key_count wraps to 0x00, seg5=seg4=C0. Pulse resetn low between E0 and the next byte -> state returns to IDLE, and the next byte 1C decodes as non-extended.
